simon_playback_ctrl: RTL and testbench

Sequences playback of the stored Simon color pattern to the lamp/VGA color outputs during the GetColor phase of the game state machine. On a Start pulse it reads entries 0..level-1 from the sequence memory one at a time, lights each color for a fixed on-time, blanks for a gap, then pulses done so the game FSM can move to user input. It owns the sequence-memory read port while busy.

---
 rtl/simon_playback_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_simon_playback_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simon_playback_ctrl
// Purpose  : Plays the stored Simon colour sequence onto the one-hot lamp
//            outputs, blanks between colours, then pulses done.
//            Optional macro PLAYBACK_SPEEDUP_EN shortens on-time for long levels.
// Revision : 1.0  initial release
// ============================================================================
module simon_playback_ctrl #(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int MAX_LEVEL  = 64,
  parameter int CNT_W      = 27
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  input  logic [6:0] level,
  output logic       seq_rd,
  output logic [5:0] seq_addr,
  input  logic [1:0] seq_data,
  output logic [3:0] color_oh,
  output logic [6:0] play_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SHOW      = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [6:0]       c_max_len    = 7'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] c_on_cycles  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] c_gap_cycles = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] c_timer_one  = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [6:0]       r_len, w_len_nxt;
  logic [6:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_seq_rd, w_seq_rd_nxt;
  logic [5:0]       r_seq_addr, w_seq_addr_nxt;
  logic [3:0]       r_color_oh, w_color_oh_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [6:0]       w_len_clamped;
  logic [6:0]       w_idx_inc;
  logic             w_last_color;
  logic             w_timer_expired;
  logic [CNT_W-1:0] w_on_time;

  function automatic logic [3:0] decode_color(input logic [1:0] code);
    logic [3:0] v;
    case (code)
      2'b00:   v = 4'b0001;
      2'b01:   v = 4'b0010;
      2'b10:   v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

  assign w_len_clamped   = (level > c_max_len) ? c_max_len : level;
  assign w_idx_inc       = r_idx + 7'd1;
  assign w_last_color    = (w_idx_inc == r_len);
  assign w_timer_expired = (r_timer == c_timer_one);

`ifdef PLAYBACK_SPEEDUP_EN
  logic [1:0]       w_shift;
  logic [CNT_W-1:0] w_on_shifted;

  // Levels 4-7 play at half on-time, 8 and above at quarter, never below 2.
  assign w_shift      = (r_len[6:3] != 4'd0) ? 2'd2 : {1'b0, r_len[2]};
  assign w_on_shifted = c_on_cycles >> w_shift;
  assign w_on_time    = (w_on_shifted < CNT_W'(2)) ? CNT_W'(2) : w_on_shifted;
`else
  assign w_on_time    = c_on_cycles;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_len      <= 7'd0;
      r_idx      <= 7'd0;
      r_timer    <= '0;
      r_seq_rd   <= 1'b0;
      r_seq_addr <= 6'd0;
      r_color_oh <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      r_seq_rd   <= w_seq_rd_nxt;
      r_seq_addr <= w_seq_addr_nxt;
      r_color_oh <= w_color_oh_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Outputs are computed for the next state so every port comes from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_idx_nxt      = r_idx;
    w_timer_nxt    = r_timer;
    w_seq_rd_nxt   = 1'b0;
    w_seq_addr_nxt = r_seq_addr;
    w_color_oh_nxt = 4'd0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start && !Abort) begin
          w_len_nxt = w_len_clamped;
          w_idx_nxt = 7'd0;
          if (w_len_clamped == 7'd0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = S_FETCH;
            w_seq_rd_nxt   = 1'b1;
            w_seq_addr_nxt = 6'd0;
            w_busy_nxt     = 1'b1;
          end
        end
      end

      S_FETCH: begin
        w_state_nxt = S_WAIT_DATA;
        w_busy_nxt  = 1'b1;
      end

      S_WAIT_DATA: begin
        w_state_nxt    = S_SHOW;
        w_busy_nxt     = 1'b1;
        w_color_oh_nxt = decode_color(seq_data);
        w_timer_nxt    = w_on_time;
      end

      S_SHOW: begin
        w_busy_nxt = 1'b1;
        if (w_timer_expired) begin
          w_state_nxt = S_GAP;
          w_timer_nxt = c_gap_cycles;
        end else begin
          w_timer_nxt    = r_timer - c_timer_one;
          w_color_oh_nxt = r_color_oh;
        end
      end

      S_GAP: begin
        if (w_timer_expired) begin
          if (w_last_color) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = S_FETCH;
            w_idx_nxt      = w_idx_inc;
            w_seq_rd_nxt   = 1'b1;
            w_seq_addr_nxt = w_idx_inc[5:0];
            w_busy_nxt     = 1'b1;
          end
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
          w_busy_nxt  = 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort drops straight to IDLE with everything dark and no done pulse.
    if (Abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_len_nxt      = r_len;
      w_idx_nxt      = r_idx;
      w_timer_nxt    = r_timer;
      w_seq_rd_nxt   = 1'b0;
      w_seq_addr_nxt = r_seq_addr;
      w_color_oh_nxt = 4'd0;
      w_busy_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
    end
  end

  assign seq_rd   = r_seq_rd;
  assign seq_addr = r_seq_addr;
  assign color_oh = r_color_oh;
  assign play_idx = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;

  a_color_onehot: assert property (@(posedge Clk) disable iff (!Reset) $onehot0(color_oh));
  a_rd_in_busy:   assert property (@(posedge Clk) disable iff (!Reset) seq_rd |-> busy);

endmodule
`default_nettype wire

// File: tb/tb_simon_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_playback_ctrl
// Purpose  : Self-checking bench for simon_playback_ctrl (ON=4, GAP=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_simon_playback_ctrl;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int MAXL = 64;
`ifdef PLAYBACK_SPEEDUP_EN
  localparam int L4_ON = 2;
  localparam int L8_ON = 2;
`else
  localparam int L4_ON = 4;
  localparam int L8_ON = 4;
`endif
  localparam int L4_SPAN = 4 * (2 + L4_ON + GAP);

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [6:0] level = 7'd0;
  logic [1:0] seq_data = 2'd0;
  logic       seq_rd;
  logic [5:0] seq_addr;
  logic [3:0] color_oh;
  logic [6:0] play_idx;
  logic       busy;
  logic       done;

  always #5 Clk = ~Clk;

  simon_playback_ctrl #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .MAX_LEVEL (MAXL),
    .CNT_W     (8)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Abort   (Abort),
    .level   (level),
    .seq_rd  (seq_rd),
    .seq_addr(seq_addr),
    .seq_data(seq_data),
    .color_oh(color_oh),
    .play_idx(play_idx),
    .busy    (busy),
    .done    (done)
  );

  logic [1:0] mem [64];
  always @(posedge Clk) if (seq_rd) seq_data <= mem[seq_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Behavioural model: position inside playback as a plain cycle offset.
  bit m_valid = 0;
  bit m_active = 0;
  int m_t, m_len, m_on, m_hold_idx, m_hold_addr;

  // Monitor bookkeeping
  int         rd_cyc_q[$];
  int         last_rd_addr = 0;
  int         done_n = 0;
  int         last_done_cyc = 0;
  logic [3:0] color_log[$];
  logic [3:0] prev_color = 4'd0;
  int         cur_run = 0;
  int         last_run = 0;

  function automatic int on_time_for(input int len);
`ifdef PLAYBACK_SPEEDUP_EN
    int s, v;
    s = (len / 4 >= 2) ? 2 : len / 4;
    v = ON >> s;
    return (v < 2) ? 2 : v;
`else
    return ON;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int p, tot;
    if (!Reset) begin
      m_valid = 1; m_active = 0; m_hold_idx = 0; m_hold_addr = 0;
    end else if (m_valid) begin
      if (m_active) begin
        p = 2 + m_on + GAP;
        tot = m_len * p;
        if (Abort || m_t == tot) begin
          if (m_t < tot) begin
            m_hold_idx = m_t / p; m_hold_addr = m_t / p;
          end else if (m_len > 0) begin
            m_hold_idx = m_len - 1; m_hold_addr = m_len - 1;
          end
          m_active = 0;
        end else begin
          m_t++;
        end
      end else if (Start && !Abort) begin
        m_active = 1; m_t = 0;
        m_len = (int'(level) > MAXL) ? MAXL : int'(level);
        m_on = on_time_for(m_len);
        m_hold_idx = 0;
      end
    end
  endtask

  task automatic compare();
    int p, tot, k, ph;
    logic e_rd, e_busy, e_done;
    logic [5:0] e_addr;
    logic [3:0] e_color;
    logic [6:0] e_idx;
    if (!m_valid) return;
    e_rd = 0; e_busy = 0; e_done = 0; e_color = 4'd0;
    e_addr = 6'(m_hold_addr); e_idx = 7'(m_hold_idx);
    if (m_active) begin
      p = 2 + m_on + GAP;
      tot = m_len * p;
      if (m_t < tot) begin
        k = m_t / p; ph = m_t % p;
        e_rd = (ph == 0); e_busy = 1; e_addr = 6'(k); e_idx = 7'(k);
        if (ph >= 2 && ph < 2 + m_on) e_color = 4'(1 << mem[k]);
      end else begin
        e_done = 1;
        if (m_len > 0) begin
          e_addr = 6'(m_len - 1); e_idx = 7'(m_len - 1);
        end
      end
    end
    chk("seq_rd", 32'(seq_rd), 32'(e_rd));
    if (e_rd) chk("seq_addr", 32'(seq_addr), 32'(e_addr));
    chk("color_oh", 32'(color_oh), 32'(e_color));
    chk("play_idx", 32'(play_idx), 32'(e_idx));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic monitor();
    cyc++;
    if (seq_rd === 1'b1) begin
      rd_cyc_q.push_back(cyc);
      last_rd_addr = int'(seq_addr);
    end
    if (done === 1'b1) begin
      done_n++;
      last_done_cyc = cyc;
    end
    if (color_oh != 4'd0 && prev_color == 4'd0) begin
      color_log.push_back(color_oh);
      cur_run = 1;
    end else if (color_oh != 4'd0) begin
      cur_run++;
    end else if (prev_color != 4'd0) begin
      last_run = cur_run;
    end
    prev_color = color_oh;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_update();
      @(negedge Clk);
      compare();
      monitor();
    end
  endtask

  task automatic start_play(input int lvl);
    level = 7'(lvl);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int budget);
    int n;
    n = 0;
    while (done_n == base_done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_n - base_done), 32'd1);
  endtask

  initial begin
    int c0, b_rd, b_lit, b_done;
    logic [3:0] exp_cols[4];
    exp_cols = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b11; mem[3] = 2'b10;
    for (int i = 4; i < 64; i++) mem[i] = 2'((i * 3 + i / 5) % 4);

    // Reset with Start held high must not start playback
    Reset = 1'b0; level = 7'd4; Start = 1'b1;
    tick(2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_color", 32'(color_oh), 32'd0);
    chk("reset_addr", 32'(seq_addr), 32'd0);
    Start = 1'b0; Reset = 1'b1;
    tick(3);
    chk("idle_busy", 32'(busy), 32'd0);

    // level 4: full playback
    b_rd = rd_cyc_q.size(); b_lit = color_log.size(); b_done = done_n; c0 = cyc;
    start_play(4);
    wait_done(b_done, 200);
    chk("l4_rd_count", 32'(rd_cyc_q.size() - b_rd), 32'd4);
    chk("l4_first_fetch", 32'(rd_cyc_q[b_rd]), 32'(c0 + 1));
    chk("l4_done_offset", 32'(last_done_cyc - rd_cyc_q[b_rd]), 32'(L4_SPAN));
    chk("l4_lit_count", 32'(color_log.size() - b_lit), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("l4_color", 32'(color_log[b_lit + i]), 32'(exp_cols[i]));
    chk("l4_on_time", 32'(last_run), 32'(L4_ON));
    tick(3);

    // level 0: immediate done
    b_rd = rd_cyc_q.size(); b_lit = color_log.size(); b_done = done_n; c0 = cyc;
    start_play(0);
    tick(2);
    chk("l0_done_count", 32'(done_n - b_done), 32'd1);
    chk("l0_done_cycle", 32'(last_done_cyc), 32'(c0 + 1));
    chk("l0_rd_count", 32'(rd_cyc_q.size() - b_rd), 32'd0);
    chk("l0_lit_count", 32'(color_log.size() - b_lit), 32'd0);

    // level 100 clamps to 64
    b_rd = rd_cyc_q.size(); b_done = done_n;
    start_play(100);
    wait_done(b_done, 700);
    chk("l100_rd_count", 32'(rd_cyc_q.size() - b_rd), 32'd64);
    chk("l100_last_addr", 32'(last_rd_addr), 32'd63);
    tick(2);

    // Abort during second colour
    b_lit = color_log.size(); b_done = done_n;
    start_play(4);
    for (int n = 0; n < 60 && (color_log.size() - b_lit) < 2; n++) tick();
    chk("abort_reached_show2", 32'(color_log.size() - b_lit), 32'd2);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_color", 32'(color_oh), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(40);
    chk("abort_no_done", 32'(done_n - b_done), 32'd0);
    b_done = done_n;
    start_play(4);
    chk("replay_rd", 32'(seq_rd), 32'd1);
    chk("replay_addr", 32'(seq_addr), 32'd0);
    wait_done(b_done, 200);
    tick(2);

    // Start and Abort together in IDLE
    b_rd = rd_cyc_q.size();
    Start = 1'b1; Abort = 1'b1; level = 7'd4;
    tick();
    Start = 1'b0; Abort = 1'b0;
    tick(3);
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_rd", 32'(rd_cyc_q.size() - b_rd), 32'd0);

    // Start and level changes while busy are ignored
    b_rd = rd_cyc_q.size(); b_done = done_n;
    start_play(4);
    tick(5);
    level = 7'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(b_done, 200);
    tick(4);
    chk("busy_start_rd_count", 32'(rd_cyc_q.size() - b_rd), 32'd4);
    chk("busy_start_no_requeue", 32'(busy), 32'd0);

    // level 8 on-time
    b_done = done_n;
    start_play(8);
    wait_done(b_done, 300);
    chk("l8_on_time", 32'(last_run), 32'(L8_ON));
    tick(2);

    // Reset mid-playback
    b_done = done_n;
    start_play(4);
    tick(6);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("midreset_idx", 32'(play_idx), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    tick(40);
    chk("midreset_no_done", 32'(done_n - b_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
